filtro_ctrl: RTL and testbench

FILTRO_CTRL -- requirements
Module: filtro_ctrl

---
 rtl/filtro_defs_pkg.sv | 19 +
 rtl/filtro_ctrl_tap_cnt.sv | 39 +++
 rtl/filtro_ctrl.sv | 112 +++++++++++
 tb/tb_filtro_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/filtro_defs_pkg.sv
// Shared filter definitions: controller state encoding and tap-select width helper.
package filtro_defs;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        MAC     = 3'd2,
        STORE   = 3'd3,
        SHIFT   = 3'd4
    } state_t;

    localparam int N_TAPS_DEFAULT = 5;

    // Width of the tap select for a given tap count; never narrower than one bit.
    function automatic int tap_width(input int n_taps);
        return (n_taps <= 2) ? 1 : $clog2(n_taps);
    endfunction

endpackage

// File: rtl/filtro_ctrl_tap_cnt.sv
// Tap counter: counts 0..LAST while enabled, returns to 0 after LAST, flags LAST as terminal count.
module tap_cnt #(
    parameter int W    = 3,
    parameter int LAST = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign cnt = cnt_q;
    assign tc  = (cnt_q == W'(LAST));

    // Next count: clear wins, otherwise step and fold back to 0 after the last tap.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc ? '0 : cnt_q + W'(1);
        end
    end

    // Count register, forced to 0 by the active-low asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/filtro_ctrl.sv
// FIR filter sequencing controller: capture, N_TAPS MAC cycles, store, shift; sticky overrun flag.
module filtro_ctrl
    import filtro_defs::*;
#(
    parameter int N_TAPS = N_TAPS_DEFAULT,
    parameter int TAP_W  = tap_width(N_TAPS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sample_valid,
    input  logic             clr_ovr,
    output logic             leer_x,
    output logic             acc_clr,
    output logic             acc_en,
    output logic [TAP_W-1:0] sel_tap,
    output logic             leer_y,
    output logic             shift_en,
    output logic             busy,
    output logic             done,
    output logic             overrun
);

    state_t           state_q;
    state_t           state_d;
    logic             overrun_q;
    logic             overrun_d;
    logic [TAP_W-1:0] tap_count;
    logic             tap_last;
    logic             in_mac;

    assign in_mac = (state_q == MAC);

    // The counter only runs during MAC and is held at 0 in every other state.
    tap_cnt #(
        .W    (TAP_W),
        .LAST (N_TAPS - 1)
    ) u_tap_cnt (
        .clk (clk),
        .rst (rst),
        .clr (!in_mac),
        .en  (in_mac),
        .cnt (tap_count),
        .tc  (tap_last)
    );

    // Next-state: a sample starts a sequence only from IDLE with en high; once started it always completes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sample_valid && en) state_d = CAPTURE;
            CAPTURE: state_d = MAC;
            MAC:     if (tap_last) state_d = STORE;
            STORE:   state_d = SHIFT;
            SHIFT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Overrun: a sample seen while not IDLE is dropped; setting takes priority over clearing.
    always_comb begin
        overrun_d = overrun_q;
        if (clr_ovr) begin
            overrun_d = 1'b0;
        end
        if (sample_valid && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    // State and overrun registers, both cleared at once by the asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            overrun_q <= overrun_d;
        end
    end

    // Moore outputs decoded purely from the registered state.
    always_comb begin
        leer_x   = 1'b0;
        acc_clr  = 1'b0;
        acc_en   = 1'b0;
        sel_tap  = '0;
        leer_y   = 1'b0;
        shift_en = 1'b0;
        done     = 1'b0;
        case (state_q)
            CAPTURE: begin
                leer_x  = 1'b1;
                acc_clr = 1'b1;
            end
            MAC: begin
                acc_en  = 1'b1;
                sel_tap = tap_count;
            end
            STORE: leer_y = 1'b1;
            SHIFT: begin
                shift_en = 1'b1;
                done     = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy    = (state_q != IDLE);
    assign overrun = overrun_q;

endmodule

// File: tb/tb_filtro_ctrl.sv
// Directed bench for filtro_ctrl with the default five taps.
module tb_filtro_ctrl;

    logic       clk;
    logic       rst;
    logic       en;
    logic       sample_valid;
    logic       clr_ovr;
    logic       leer_x;
    logic       acc_clr;
    logic       acc_en;
    logic [2:0] sel_tap;
    logic       leer_y;
    logic       shift_en;
    logic       busy;
    logic       done;
    logic       overrun;

    logic [10:0] obs;
    logic [10:0] expected;

    int numChecks;
    int numFails;

    filtro_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .sample_valid (sample_valid),
        .clr_ovr      (clr_ovr),
        .leer_x       (leer_x),
        .acc_clr      (acc_clr),
        .acc_en       (acc_en),
        .sel_tap      (sel_tap),
        .leer_y       (leer_y),
        .shift_en     (shift_en),
        .busy         (busy),
        .done         (done),
        .overrun      (overrun)
    );

    assign obs = {leer_x, acc_clr, acc_en, sel_tap, leer_y, shift_en, busy, done, overrun};

    // Free-running 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count a comparison and report any difference.
    task automatic checkOutput(input string tag, input int cyc, input logic [10:0] got, input logic [10:0] exp);
        numChecks++;
        if (got !== exp) begin
            numFails++;
            $display("[TB] FAIL %s cycle %0d: got %b expected %b (lx ac ae sel[3] ly se busy done ovr)",
                     tag, cyc, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic sv, input logic e, input logic c);
        sample_valid = sv;
        en           = e;
        clr_ovr      = c;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hand timing for a sample accepted at edge s: capture at s+1, taps 0..4 at s+2..s+6,
    // store at s+7, shift+done at s+8. Overrun bit is left 0.
    function automatic logic [10:0] expSeq(input int k, input int s);
        logic       lx, ac, ae, ly, se, bz, dn;
        logic [2:0] st;
        int         d;
        lx = 0; ac = 0; ae = 0; ly = 0; se = 0; bz = 0; dn = 0; st = 3'd0;
        d = k - s;
        if (d == 1) begin
            lx = 1; ac = 1; bz = 1;
        end else if (d >= 2 && d <= 6) begin
            ae = 1; st = 3'(d - 2); bz = 1;
        end else if (d == 7) begin
            ly = 1; bz = 1;
        end else if (d == 8) begin
            se = 1; dn = 1; bz = 1;
        end
        return {lx, ac, ae, st, ly, se, bz, dn, 1'b0};
    endfunction

    // Hold reset over two edges, check the reset state, release mid-cycle before edge 1.
    task automatic doReset();
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3;
        checkOutput("resetState", 0, obs, 11'd0);
        rst = 1'b1;
    endtask

    initial begin
        numChecks = 0;
        numFails  = 0;
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0);

        $display("[TB] scenario A: nominal sequence, overrun and clear");
        doReset();
        for (int k = 1; k <= 32; k++) begin
            applyStimulus((k == 10) || (k == 14), 1'b1, (k == 30));
            expected    = expSeq(k, 10);
            expected[0] = (k >= 15) && (k <= 30);
            checkOutput("seqOverrun", k, obs, expected);
            step();
        end

        $display("[TB] scenario B: sample ignored while disabled");
        doReset();
        for (int k = 1; k <= 10; k++) begin
            applyStimulus((k == 5), 1'b0, 1'b0);
            checkOutput("disabledIdle", k, obs, 11'd0);
            step();
        end

        $display("[TB] scenario C: reset pulse mid-sequence");
        doReset();
        for (int k = 1; k <= 34; k++) begin
            applyStimulus((k == 10) || (k == 25), 1'b1, 1'b0);
            expected = ((k <= 14) ? expSeq(k, 10) : 11'd0) | expSeq(k, 25);
            checkOutput("midReset", k, obs, expected);
            if (k == 14) begin
                #2;
                rst = 1'b0;
                #1;
                checkOutput("asyncReset", k, obs, 11'd0);
                #2;
                rst = 1'b1;
            end
            step();
        end

        $display("[TB] scenario D: set beats clear on the same edge");
        doReset();
        for (int k = 1; k <= 20; k++) begin
            applyStimulus((k == 10) || (k == 14) || (k == 16), 1'b1, (k == 16));
            expected    = expSeq(k, 10);
            expected[0] = (k >= 15);
            checkOutput("setWins", k, obs, expected);
            step();
        end

        $display("[TB] scenario E: back-to-back samples, en dropped mid-sequence");
        doReset();
        for (int k = 1; k <= 28; k++) begin
            applyStimulus((k == 10) || (k == 19), !((k >= 12) && (k <= 15)), 1'b0);
            expected = expSeq(k, 10) | expSeq(k, 19);
            checkOutput("backToBack", k, obs, expected);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
